// File: rtl/ifq_pkg.sv
// Shared fetch-queue types: FSM states, queue entry layout, default widths and reset fetch address.
package ifq_pkg;

    localparam int unsigned IFQ_AW       = 12;
    localparam int unsigned IFQ_DW       = 32;
    localparam int unsigned IFQ_RESET_PC = 0;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FULL
    } ifq_state_e;

    typedef struct packed {
        logic [IFQ_DW-1:0] instr;
        logic [IFQ_AW-1:0] pc;
    } ifq_entry_t;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned ifq_cw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with flush and occupancy; head visible the cycle after a push into an empty queue.
// No internal overflow guard: the producer only pushes when it holds a credit.
module ifq_fifo import ifq_pkg::*; #(
    parameter  int unsigned W     = 44,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = ifq_cw(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_dat_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// In-order instruction fetch with credit-limited imem requests and a decode queue; resp->decode 1 cycle.
// Requests stop when queue+in-flight fills DEPTH or MAX_OUT; `IFQ_PERF_CNT_EN adds stall_cycles.
module instr_fetch_queue import ifq_pkg::*; #(
    parameter int unsigned AW       = IFQ_AW,
    parameter int unsigned DW       = IFQ_DW,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 4,
    parameter int unsigned RESET_PC = IFQ_RESET_PC
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          fetch_en,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_resp_valid,
    input  logic [DW-1:0] imem_resp_data,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [DW-1:0] dec_instr,
    output logic [AW-1:0] dec_pc
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cycles
`endif
);

    localparam int unsigned   CW     = ifq_cw(DEPTH);
    localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    ifq_state_e    state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] discard_q, discard_d;

    logic          req_acc;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [CW-1:0] occ;
    logic [CW-1:0] occ_d;
    logic [CW:0]   total_d;
    logic          credit_full;
    entry_t        push_entry;
    entry_t        head_entry;

    // Redirect outranks everything: no accept, push or pop in that cycle.
    assign req_acc = imem_req_valid && imem_req_ready;
    assign push    = imem_resp_valid && !redirect_valid && (discard_q == '0);
    assign pop     = dec_valid && dec_ready && !redirect_valid;

    assign push_entry = '{instr: imem_resp_data, pc: resp_pc_q};

    ifq_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush_i    (redirect_valid),
        .push_i     (push),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .head_dat_o (head_entry),
        .empty_o    (fifo_empty),
        .count_o    (occ)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        out_d      = out_q;
        if (req_acc)         out_d = out_d + CW'(1);
        if (imem_resp_valid) out_d = out_d - CW'(1);
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            // Whatever is still in flight after this cycle belongs to the old path.
            discard_d  = out_q - CW'(imem_resp_valid);
        end else begin
            if (req_acc) fetch_pc_d = fetch_pc_q + AW'(1);
            if (imem_resp_valid) begin
                if (discard_q != '0) discard_d = discard_q - CW'(1);
                else                 resp_pc_d = resp_pc_q + AW'(1);
            end
        end
    end

    // Credit is judged on next-cycle totals so a request is never issued without a queue slot.
    always_comb begin
        occ_d       = redirect_valid ? '0 : (occ + CW'(push) - CW'(pop));
        total_d     = {1'b0, occ_d} + {1'b0, out_d};
        credit_full = (total_d >= (CW+1)'(DEPTH)) || (out_d >= CW'(MAX_OUT));
    end

    always_comb begin
        state_d        = state_q;
        imem_req_valid = (state_q == S_RUN) && fetch_en && !redirect_valid;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (credit_full)  state_d = S_FULL;
            S_FULL:  if (!credit_full) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= RST_PC;
            resp_pc_q  <= RST_PC;
            out_q      <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            discard_q  <= discard_d;
        end
    end

    assign imem_req_addr = fetch_pc_q;
    assign dec_valid     = !fifo_empty;
    assign dec_instr     = dec_valid ? head_entry.instr : '0;
    assign dec_pc        = dec_valid ? head_entry.pc    : '0;

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (dec_ready && !dec_valid && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with an in-order instruction memory model and a decode consumer.
module tb_instr_fetch_queue;

    logic        clock;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [11:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [11:0] dec_pc;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] exp_req;
    logic [11:0] exp_dec;
    logic        hold_resp;
    logic [11:0] pend[$];
    int          n;

    instr_fetch_queue dut (
        .clock           (clock),
        .reset           (reset),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc)
`ifdef IFQ_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] dat(input logic [11:0] a);
        return {20'hA5000, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: score handshakes before the edge, then play the memory after it.
    task automatic tick();
        logic        acc;
        logic [11:0] a;
        #2;
        acc = !reset && imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        if (!reset && !redirect_valid && dec_valid && dec_ready) begin
            chk("dec_pc", dec_pc, exp_dec);
            chk("dec_instr", dec_instr, dat(exp_dec));
            exp_dec = exp_dec + 12'd1;
        end
        if (acc) begin
            chk("req_addr", a, exp_req);
            exp_req = exp_req + 12'd1;
        end
        @(posedge clock);
        #1;
        if (reset)    pend.delete();
        else if (acc) pend.push_back(a);
        if (!hold_resp && pend.size() != 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = dat(pend.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_vld"},  imem_req_valid, 0);
        chk({tag, "_dec_vld"},  dec_valid, 0);
        chk({tag, "_req_addr"}, imem_req_addr, 0);
        chk({tag, "_dec_instr"}, dec_instr, 0);
        chk({tag, "_dec_pc"},   dec_pc, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        dec_ready = 1'b0; hold_resp = 1'b0; exp_req = '0; exp_dec = '0;

        repeat (3) tick();
        chk_reset_outputs("a_rst");
`ifdef IFQ_PERF_CNT_EN
        chk("a_perf_rst", stall_cycles, 0);
`endif

        // Basic streaming from RESET_PC.
        reset = 1'b0; fetch_en = 1'b1; imem_req_ready = 1'b1; dec_ready = 1'b1;
        tick();
        chk("b_req_vld", imem_req_valid, 1);
        chk("b_req_addr", imem_req_addr, 0);
        chk("b_dec_empty", dec_valid, 0);
        tick();
        tick();
        chk("b_first_vld", dec_valid, 1);
        chk("b_first_pc", dec_pc, 0);
        chk("b_first_instr", dec_instr, dat(12'h000));
        repeat (8) tick();

        // Decode back-pressure: queue fills to DEPTH, then drains in order.
        dec_ready = 1'b0;
        repeat (10) tick();
        chk("c_req_hold", imem_req_valid, 0);
        chk("c_head_vld", dec_valid, 1);
        chk("c_head_pc", dec_pc, exp_dec);
        fetch_en = 1'b0; dec_ready = 1'b1; n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!dec_valid) break;
            n++;
            tick();
        end
        chk("c_drain_cnt", n, 4);
        fetch_en = 1'b1;
        repeat (6) tick();

        // Redirect with three requests in flight.
        fetch_en = 1'b0;
        repeat (4) tick();
        chk("d_drained", dec_valid, 0);
        hold_resp = 1'b1; fetch_en = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 12'h100;
        #1;
        chk("d_withdraw", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0; hold_resp = 1'b0;
        exp_req = 12'h100; exp_dec = 12'h100;
        for (int i = 0; i < 20; i++) begin
            if (dec_valid) break;
            tick();
        end
        chk("d_first_vld", dec_valid, 1);
        chk("d_first_pc", dec_pc, 12'h100);
        tick();
        for (int i = 0; i < 20; i++) begin
            if (dec_valid) break;
            tick();
        end
        chk("d_second_pc", dec_pc, 12'h101);

        // Redirect landing on a response and a pop in the same cycle.
        fetch_en = 1'b0;
        repeat (8) tick();
        fetch_en = 1'b1;
        repeat (5) tick();
        chk("e_pre_vld", dec_valid, 1);
        redirect_valid = 1'b1; redirect_pc = 12'h200;
        tick();
        redirect_valid = 1'b0;
        exp_req = 12'h200; exp_dec = 12'h200;
        #1;
        chk("e_flushed", dec_valid, 0);
        chk("e_req_vld", imem_req_valid, 1);
        chk("e_req_addr", imem_req_addr, 12'h200);
        for (int i = 0; i < 20; i++) begin
            if (dec_valid) break;
            tick();
        end
        chk("e_first_pc", dec_pc, 12'h200);
        repeat (3) tick();

        // Address wrap 0xFFF -> 0x000.
        redirect_valid = 1'b1; redirect_pc = 12'hFFE;
        tick();
        redirect_valid = 1'b0;
        exp_req = 12'hFFE; exp_dec = 12'hFFE;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (imem_req_valid && imem_req_addr == 12'hFFF) break;
            tick();
        end
        chk("f_hit_fff", imem_req_addr, 12'hFFF);
        tick();
        chk("f_req_wrap", imem_req_addr, 12'h000);
        chk("f_req_vld", imem_req_valid, 1);
        for (int i = 0; i < 10; i++) begin
            if (dec_valid && dec_pc == 12'hFFF) break;
            tick();
        end
        chk("f_dec_fff", dec_pc, 12'hFFF);
        tick();
        chk("f_dec_wrap", dec_pc, 12'h000);
        chk("f_dec_wrap_instr", dec_instr, dat(12'h000));

        // Reset mid-stream with two requests in flight.
        fetch_en = 1'b0;
        repeat (8) tick();
        chk("g_drained", dec_valid, 0);
        hold_resp = 1'b1; fetch_en = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk_reset_outputs("g_rst");
        hold_resp = 1'b0; reset = 1'b0;
        exp_req = '0; exp_dec = '0;
        for (int i = 0; i < 10; i++) begin
            if (dec_valid) break;
            tick();
        end
        chk("g_restart_pc", dec_pc, 12'h000);
        chk("g_restart_instr", dec_instr, dat(12'h000));
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
